// File: rtl/data_mem_responder_pkg.sv
// +----------------------------------------------------------------------+
// | data_mem_responder_pkg : shared FSM encoding and bus width defaults  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package data_mem_responder_pkg;

  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_ADDR_W = 32;
  localparam int unsigned C_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// +----------------------------------------------------------------------+
// | data_mem_responder_if : valid/ready load/store request and response  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = C_ADDR_W,
  parameter int unsigned DATA_W = C_DATA_W
);

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_responder_mem_array_1rw.sv
// +----------------------------------------------------------------------+
// | mem_array_1rw : single-port array, synchronous write and read reg    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_array_1rw #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 10
) (
  input  wire logic              CLK,
  input  wire logic              en,
  input  wire logic              we,
  input  wire logic [IDX_W-1:0]  addr,
  input  wire logic [DATA_W-1:0] wdata,
  output      logic [DATA_W-1:0] rdata
);

  // Power-up contents are zero; reset never touches the array.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------+
// | data_mem_responder : fixed-latency load/store responder over a       |
// | word-addressed data array                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned DATA_W  = C_DATA_W,
  parameter int unsigned ADDR_W  = C_ADDR_W,
  parameter int unsigned LATENCY = 2
) (
  input wire logic             CLK,
  input wire logic             RST_N,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned           IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_CNT_W-1:0]    C_CNT_LOAD = C_CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0]     C_DEPTH    = ADDR_W'(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [C_CNT_W-1:0]  w_cnt_nxt;
  logic                w_accept;
  logic                w_commit;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic                r_rd_ok;

  logic                w_c_we;
  logic [ADDR_W-1:0]   w_c_addr;
  logic [DATA_W-1:0]   w_c_wdata;
  logic                w_in_range;
  logic                w_mem_en;
  logic [DATA_W-1:0]   w_mem_rdata;

  // With LATENCY==1 the commit coincides with acceptance, so it must see
  // the live request rather than the not-yet-loaded holding registers.
  assign w_c_we     = (r_state == IDLE) ? bus.REQ_WE    : r_we;
  assign w_c_addr   = (r_state == IDLE) ? bus.REQ_ADDR  : r_addr;
  assign w_c_wdata  = (r_state == IDLE) ? bus.REQ_WDATA : r_wdata;
  assign w_in_range = (w_c_addr < C_DEPTH);
  assign w_mem_en   = w_commit && w_in_range;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.REQ_VALID && RST_N) begin
          w_accept  = 1'b1;
          w_cnt_nxt = C_CNT_LOAD;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - C_CNT_W'(1);
        if (r_cnt == C_CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_commit    = RST_N;
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) begin
        r_err   <= !w_in_range;
        r_rd_ok <= w_in_range && !w_c_we;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_we    <= bus.REQ_WE;
      r_addr  <= bus.REQ_ADDR;
      r_wdata <= bus.REQ_WDATA;
    end
  end

  mem_array_1rw #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .CLK   (CLK),
    .en    (w_mem_en),
    .we    (w_c_we),
    .addr  (w_c_addr[IDX_W-1:0]),
    .wdata (w_c_wdata),
    .rdata (w_mem_rdata)
  );

  assign bus.REQ_READY = (r_state == IDLE) && RST_N;
  assign bus.RSP_VALID = (r_state == RESP);
  assign bus.RSP_ERR   = (r_state == RESP) && r_err;
  assign bus.RSP_RDATA = ((r_state == RESP) && r_rd_ok) ? w_mem_rdata : '0;

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory that acts as the responder on the processor's load/store port. It replaces the zero-wait combinational data memory.
- Uses a valid/ready request channel and a valid/ready response channel, with a fixed, parameterised access latency.
- Sits between the core's load/store path (ALU address, RD2 write data, MemWrite) and the backing storage array.
- Lets the processor be stalled or run multi-cycle against realistic memory timing.

Parameters:
DEPTH, 1024, number of 32-bit words in the storage array; legal addresses are 0..DEPTH-1.
DATA_W, 32, data word width.
ADDR_W, 32, request address width; word address, not byte address.
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
CLK  in  1  clock; all state updates on posedge.
RST_N  in  1  synchronous active-low reset, sampled on posedge CLK.
REQ_VALID  in  1  initiator presents a request.
REQ_READY  out  1  responder can accept a request.
REQ_WE  in  1  1 = store, 0 = load.
REQ_ADDR  in  ADDR_W  word address.
REQ_WDATA  in  DATA_W  store data.
RSP_VALID  out  1  response available.
RSP_READY  in  1  initiator accepts the response.
RSP_RDATA  out  DATA_W  load data; 0 for stores and for errors.
RSP_ERR  out  1  address was out of range (REQ_ADDR >= DEPTH).

Behaviour:
- Reset: synchronous active-low. While RST_N=0 at a posedge:
  - state returns to IDLE and the latency counter clears.
  - REQ_READY=0 during the reset cycle, then 1 in IDLE.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0.
- Storage array is not cleared by reset; it is zero-initialised at time 0 only.
- Reset mid-operation aborts the transaction. A captured store that has not yet committed is discarded, and no response is issued.
- States: IDLE, WAIT, RESP. REQ_READY=1 only in IDLE. RSP_VALID=1 only in RESP.
- IDLE:
  - On REQ_VALID & REQ_READY at posedge t0, capture addr, we and wdata into holding registers.
  - Load counter with LATENCY-1.
  - Go to WAIT; if LATENCY==1, go directly to RESP.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1 at a posedge, go to RESP.
  - Net effect: RSP_VALID is first high in the cycle following posedge t0+LATENCY.
- Commit: on the transition into RESP (posedge t0+LATENCY):
  - Store, in range: array[addr] <= wdata; RSP_RDATA=0; RSP_ERR=0.
  - Load, in range: RSP_RDATA <= array[addr]; RSP_ERR=0.
  - Out of range: no array access; RSP_RDATA=0; RSP_ERR=1.
- RESP:
  - RSP_VALID, RSP_RDATA and RSP_ERR hold stable until RSP_READY=1 at a posedge.
  - On that handshake, go to IDLE.
  - No back-to-back acceptance: REQ_READY rises the cycle after the response handshake.
- Request inputs are ignored outside IDLE. Inputs are sampled only at acceptance; later changes to REQ_ADDR, REQ_WDATA or REQ_WE have no effect.
- Read-after-write: a load issued after a store's response sees the stored value.
- Address compare uses the full ADDR_W width. The address is never truncated or wrapped, so addr = DEPTH is an error, not index 0.
- Only one transaction is outstanding at a time; there is no buffering beyond the single holding register.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - DATA_W/ADDR_W default constants, shared with the processor's memory port.
- One sub-module: mem_array_1rw, a DEPTH x DATA_W single-port array with synchronous write enable and synchronous read register, instantiated once.
- The FSM, latency counter and range check stay in data_mem_responder.

Test Plan:
- Reset then idle: hold RST_N=0 for 2 cycles, then release → REQ_READY=1 next cycle; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0.
- Store then load, LATENCY=2:
  - Store to addr 5 with data 0xDEADBEEF, RSP_READY=1 → RSP_VALID high exactly 2 cycles after acceptance; RSP_ERR=0.
  - Then load addr 5 → RSP_RDATA=0xDEADBEEF, 2 cycles after acceptance.
- Response backpressure: load addr 5 with RSP_READY=0 for 4 cycles → RSP_VALID and RSP_RDATA=0xDEADBEEF hold stable; REQ_READY=0 throughout. Raise RSP_READY → IDLE next cycle.
- Out of range: store to addr 1024 with data 0x1 → RSP_ERR=1 and RSP_RDATA=0. A subsequent load of addr 0 returns 0, confirming no wrap.
- Reset mid-operation: accept a store of 0x12345678 to addr 7, then assert RST_N=0 in the WAIT cycle → no RSP_VALID. A later load of addr 7 returns 0.
- LATENCY=1 build: load addr 3 (preloaded with 0xA5A5A5A5) → RSP_VALID high one cycle after acceptance with RSP_RDATA=0xA5A5A5A5.
